// File: rtl/lvda_timing_gen.sv
// LVDA master timing generator: four-phase W/X/Y/Z drive, bit-time and word-phase
// sequencing, with run / single-word-step control that always halts on a word boundary.
module lvda_timing_gen #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       RUN,
    input  logic       STEP,
    output logic       WDA,
    output logic       XDA,
    output logic       YDA,
    output logic       ZDA,
    output logic [3:0] BIT_TIME,
    output logic [1:0] PHASE,
    output logic       WORD_START,
    output logic       BUSY
);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [1:0] RING_W     = 2'd0;
    localparam logic [1:0] RING_Z     = 2'd3;
    localparam logic [3:0] BIT_LAST   = 4'd13;
    localparam logic [1:0] PHASE_LAST = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_RUNNING
    } state_t;

    state_t     state_q;
    logic       step_mode_q;
    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;
    logic [1:0] ring_q;
    logic [1:0] ring_d;
    logic [3:0] bit_q;
    logic [3:0] bit_d;
    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic       word_end;
    logic       start_word;
    logic       continue_run;
    logic [3:0] drive_oh_q;
    logic [3:0] drive_oh_d;
    logic       word_start_q;
    logic       word_start_d;
    logic       busy_q;

    // Counter advance while running; word_end marks the Z->W edge that closes phase 2, bit 13.
    always_comb begin
        div_cnt_d = div_cnt_q + 8'd1;
        ring_d    = ring_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        word_end  = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 8'd0;
            ring_d    = ring_q + 2'd1;
            if (ring_q == RING_Z) begin
                if (bit_q == BIT_LAST) begin
                    bit_d = 4'd0;
                    if (phase_q == PHASE_LAST) begin
                        phase_d  = 2'd0;
                        word_end = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
        end
    end

    assign start_word   = RUN | STEP;
    assign continue_run = RUN & ~step_mode_q;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_drive
        assign drive_oh_d[gi] = (ring_d == 2'(gi));
    end

    assign word_start_d = (ring_d == RING_W) && (bit_d == 4'd0) && (phase_d == 2'd0);

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q      <= ST_IDLE;
            step_mode_q  <= 1'b0;
            div_cnt_q    <= 8'd0;
            ring_q       <= RING_W;
            bit_q        <= 4'd0;
            phase_q      <= 2'd0;
            drive_oh_q   <= 4'd0;
            word_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_word) begin
                        state_q      <= ST_RUNNING;
                        step_mode_q  <= ~RUN;
                        div_cnt_q    <= 8'd0;
                        ring_q       <= RING_W;
                        bit_q        <= 4'd0;
                        phase_q      <= 2'd0;
                        drive_oh_q   <= 4'b0001;
                        word_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (word_end && !continue_run) begin
                        state_q      <= ST_IDLE;
                        step_mode_q  <= 1'b0;
                        div_cnt_q    <= 8'd0;
                        ring_q       <= RING_W;
                        bit_q        <= 4'd0;
                        phase_q      <= 2'd0;
                        drive_oh_q   <= 4'd0;
                        word_start_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else begin
                        // On a continuing word_end the _d counters are already all zero (W, bit 0, phase 0).
                        div_cnt_q    <= div_cnt_d;
                        ring_q       <= ring_d;
                        bit_q        <= bit_d;
                        phase_q      <= phase_d;
                        drive_oh_q   <= drive_oh_d;
                        word_start_q <= word_start_d;
                        busy_q       <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign WDA        = drive_oh_q[0];
    assign XDA        = drive_oh_q[1];
    assign YDA        = drive_oh_q[2];
    assign ZDA        = drive_oh_q[3];
    assign BIT_TIME   = bit_q;
    assign PHASE      = phase_q;
    assign WORD_START = word_start_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_lvda_timing_gen.sv
// Scoreboard bench for lvda_timing_gen: two instances (CLK_DIV 1 and 3); per-word records
// queued by the stimulus are popped and compared by a cycle-level monitor on each word end.
`timescale 1ns/1ps
module tb_lvda_timing_gen;

    typedef struct packed {
        int len;
        int w;
        int x;
        int y;
        int z;
        int wsw;
        int gap;
    } word_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       run   [2];
    logic       step  [2];
    logic       wda   [2];
    logic       xda   [2];
    logic       yda   [2];
    logic       zda   [2];
    logic       ws    [2];
    logic       busy  [2];
    logic [3:0] bit_t [2];
    logic [1:0] phs   [2];

    word_rec_t q0[$];
    word_rec_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    function automatic void push_rec(input int idx, input word_rec_t r);
        if (idx == 0) q0.push_back(r);
        else q1.push_back(r);
    endfunction

    // A complete word: 168 phases of `div` cycles, 42 of each phase.
    function automatic void push_word(input int idx, input int div, input int gap);
        word_rec_t r;
        r.len = 168 * div;
        r.w   = 42 * div;
        r.x   = 42 * div;
        r.y   = 42 * div;
        r.z   = 42 * div;
        r.wsw = div;
        r.gap = gap;
        push_rec(idx, r);
    endfunction

    function automatic void pop_exp(input int idx, output word_rec_t r, output bit ok);
        ok = 1'b0;
        r  = '0;
        if (idx == 0) begin
            if (q0.size() > 0) begin
                r  = q0.pop_front();
                ok = 1'b1;
            end
        end else begin
            if (q1.size() > 0) begin
                r  = q1.pop_front();
                ok = 1'b1;
            end
        end
    endfunction

    // {BUSY, WORD_START, ZDA, YDA, XDA, WDA, PHASE, BIT_TIME}
    function automatic int out_vec(input int idx);
        return int'({busy[idx], ws[idx], zda[idx], yda[idx], xda[idx], wda[idx], phs[idx], bit_t[idx]});
    endfunction

    localparam int START_VEC = 32'h0000_0C40;

    task automatic check_idle(input int idx, input string name);
        check(name, out_vec(idx), 0);
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int n = 0;
        while (busy[idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", int'(busy[idx]), 0);
    endtask

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_inst
        localparam int DIV = (gi == 0) ? 1 : 3;

        lvda_timing_gen #(.CLK_DIV(DIV)) u_dut (
            .SIM_CLK    (clk),
            .SIM_RST    (rst[gi]),
            .RUN        (run[gi]),
            .STEP       (step[gi]),
            .WDA        (wda[gi]),
            .XDA        (xda[gi]),
            .YDA        (yda[gi]),
            .ZDA        (zda[gi]),
            .BIT_TIME   (bit_t[gi]),
            .PHASE      (phs[gi]),
            .WORD_START (ws[gi]),
            .BUSY       (busy[gi])
        );

        int         cyc      = 0;
        int         gap      = 0;
        int         idle_cnt = 0;
        int         seq_err  = 0;
        int         wsw      = 0;
        int         words    = 0;
        int         cnt [4];
        bit         in_word  = 1'b0;
        bit         prev_ws  = 1'b0;
        bit         ws_rise;
        bit         got;
        logic [3:0] oh;
        word_rec_t  r;

        always @(negedge clk) begin
            oh      = {zda[gi], yda[gi], xda[gi], wda[gi]};
            ws_rise = ws[gi] && !prev_ws;
            if (in_word && (!busy[gi] || ws_rise)) begin
                words++;
                pop_exp(gi, r, got);
                $display("inst %0d (div %0d) word %0d: len=%0d W/X/Y/Z=%0d/%0d/%0d/%0d ws_width=%0d gap=%0d seq_err=%0d",
                         gi, DIV, words, cyc, cnt[0], cnt[1], cnt[2], cnt[3], wsw, gap, seq_err);
                check("word_expected", int'(got), 1);
                if (got) begin
                    check("word_len", cyc, r.len);
                    check("word_w_cycles", cnt[0], r.w);
                    check("word_x_cycles", cnt[1], r.x);
                    check("word_y_cycles", cnt[2], r.y);
                    check("word_z_cycles", cnt[3], r.z);
                    check("word_start_width", wsw, r.wsw);
                    if (r.gap >= 0) check("word_gap", gap, r.gap);
                    check("word_sequence_errors", seq_err, 0);
                end
                in_word = 1'b0;
            end
            if (ws_rise) begin
                in_word  = 1'b1;
                gap      = idle_cnt;
                idle_cnt = 0;
                cyc      = 0;
                wsw      = 0;
                seq_err  = 0;
                cnt      = '{0, 0, 0, 0};
            end
            if (in_word) begin
                // Reference position within the word from the cycle count alone.
                if (oh != (4'b0001 << ((cyc / DIV) % 4))) seq_err++;
                if (int'(bit_t[gi]) != (cyc / (4 * DIV)) % 14) seq_err++;
                if (int'(phs[gi]) != (cyc / (56 * DIV)) % 3) seq_err++;
                if (ws[gi] != (cyc < DIV)) seq_err++;
                for (int k = 0; k < 4; k++) if (oh[k]) cnt[k]++;
                if (ws[gi]) wsw++;
                cyc++;
            end else if (!busy[gi]) begin
                idle_cnt++;
            end
            prev_ws = ws[gi];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        word_rec_t rr;
        int        n;
        for (int i = 0; i < 2; i++) begin
            rst[i]  = 1'b1;
            run[i]  = 1'b0;
            step[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "reset_state_div1");
        check_idle(1, "reset_state_div3");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check_idle(0, "idle_after_reset");

        // Continuous RUN, CLK_DIV=1; drop RUN at bit 5, phase 1 of the third word.
        push_word(0, 1, -1);
        push_word(0, 1, 0);
        push_word(0, 1, 0);
        run[0] = 1'b1;
        @(negedge clk);
        check("start_latency_div1", out_vec(0), START_VEC);
        repeat (412) @(negedge clk);
        check("drop_point_phase_bit", int'({phs[0], bit_t[0]}), 32'h15);
        run[0] = 1'b0;
        wait_idle(0, 400);
        check_idle(0, "halt_after_word");

        // Single STEP, with a second STEP mid-word that must be ignored.
        push_word(0, 1, -1);
        step[0] = 1'b1;
        @(negedge clk);
        step[0] = 1'b0;
        check("step_start", out_vec(0), START_VEC);
        repeat (50) @(negedge clk);
        step[0] = 1'b1;
        @(negedge clk);
        step[0] = 1'b0;
        wait_idle(0, 400);
        repeat (20) @(negedge clk);
        check_idle(0, "step_stays_idle");

        // STEP word with RUN rising mid-word: next word starts after one idle cycle,
        // then SIM_RST during Y of bit 7 abandons it.
        push_word(0, 1, -1);
        rr = '{len: 31, w: 8, x: 8, y: 8, z: 7, wsw: 1, gap: 1};
        push_rec(0, rr);
        step[0] = 1'b1;
        @(negedge clk);
        step[0] = 1'b0;
        repeat (60) @(negedge clk);
        run[0] = 1'b1;
        wait_idle(0, 400);
        n = 0;
        while (!(yda[0] && bit_t[0] == 4'd7) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_y_bit7", int'(yda[0] && bit_t[0] == 4'd7), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        check_idle(0, "reset_midword");
        rst[0] = 1'b0;
        push_word(0, 1, 1);
        @(negedge clk);
        check("restart_after_reset", out_vec(0), START_VEC);
        run[0] = 1'b0;
        wait_idle(0, 400);

        // RUN and STEP together from IDLE: RUN wins, second word follows with no gap.
        push_word(0, 1, -1);
        push_word(0, 1, 0);
        repeat (5) @(negedge clk);
        run[0]  = 1'b1;
        step[0] = 1'b1;
        @(negedge clk);
        step[0] = 1'b0;
        check("run_step_start", out_vec(0), START_VEC);
        repeat (200) @(negedge clk);
        run[0] = 1'b0;
        wait_idle(0, 400);
        check_idle(0, "run_step_halt");

        // CLK_DIV=3 continuous run.
        push_word(1, 3, -1);
        push_word(1, 3, 0);
        run[1] = 1'b1;
        @(negedge clk);
        check("start_latency_div3", out_vec(1), START_VEC);
        repeat (2) @(negedge clk);
        check("div3_w_held", int'({zda[1], yda[1], xda[1], wda[1]}), 1);
        @(negedge clk);
        check("div3_x_next", int'({zda[1], yda[1], xda[1], wda[1]}), 2);
        repeat (600) @(negedge clk);
        run[1] = 1'b0;
        wait_idle(1, 800);
        check_idle(1, "div3_halt");

        repeat (3) @(negedge clk);
        check("unconsumed_words_div1", q0.size(), 0);
        check("unconsumed_words_div3", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
